// File: rtl/seg_display_pkg.sv
// seg_display_pkg -- shared definitions for the seven-segment display controller.
//   - FSM state encodings (plain localparams, legacy-compatible)
//   - glyph constants in active-low form: SEG_BLANK, SEG_MINUS
//   - SHIFT_ITERS: number of double-dabble iterations for an 8-bit value
//   - dd_t / dd_step: double-dabble working register and one iteration of it
//   - hex_glyph: active-low glyph for a hex nibble, bit order {g,f,e,d,c,b,a}
package seg_display_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_UPDATE = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;  // only segment g lit

  localparam int SHIFT_ITERS = 8;

  // BCD digits above the binary operand; the binary part shifts out the top
  // into the units digit one bit per iteration.
  typedef struct packed {
    logic [3:0] hun;
    logic [3:0] ten;
    logic [3:0] one;
    logic [7:0] bin;
  } dd_t;

  // One double-dabble step: add 3 to every BCD digit of 5 or more, then shift
  // the whole register left by one bit.
  function automatic dd_t dd_step(input dd_t d);
    dd_t a;
    a = d;
    if (a.hun >= 4'd5) a.hun = a.hun + 4'd3;
    if (a.ten >= 4'd5) a.ten = a.ten + 4'd3;
    if (a.one >= 4'd5) a.one = a.one + 4'd3;
    return {a[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0:    hex_glyph = 7'b1000000;
      4'h1:    hex_glyph = 7'b1111001;
      4'h2:    hex_glyph = 7'b0100100;
      4'h3:    hex_glyph = 7'b0110000;
      4'h4:    hex_glyph = 7'b0011001;
      4'h5:    hex_glyph = 7'b0010010;
      4'h6:    hex_glyph = 7'b0000010;
      4'h7:    hex_glyph = 7'b1111000;
      4'h8:    hex_glyph = 7'b0000000;
      4'h9:    hex_glyph = 7'b0010000;
      4'hA:    hex_glyph = 7'b0001000;
      4'hB:    hex_glyph = 7'b0000011;
      4'hC:    hex_glyph = 7'b1000110;
      4'hD:    hex_glyph = 7'b0100001;
      4'hE:    hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;  // F
    endcase
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// seg7_encoder -- combinational nibble to seven-segment encoder.
//   nibble : 4-bit value, shown as 0-9 / A-F
//   blank  : 1 forces every segment dark
//   seg    : segments {g,f,e,d,c,b,a}; low = lit when SEG_ACTIVE_LOW=1,
//            high = lit when SEG_ACTIVE_LOW=0
module seg7_encoder
  import seg_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] glyph_low;

  // NOTE: every output of an always_comb gets a value on every path (here by
  // full if/else coverage); a path that skips an assignment infers a latch.
  always_comb begin
    if (blank) glyph_low = SEG_BLANK;
    else       glyph_low = hex_glyph(nibble);
    seg = SEG_ACTIVE_LOW ? glyph_low : ~glyph_low;
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl -- shows an 8-bit data value in decimal on hex3..hex0 and an
// instruction pointer in hex on hex5..hex4.
//   clk        : system clock (50 MHz)
//   resetn_deb : asynchronous active-low reset, already debounced
//   dout/dval  : data value and its valid strobe, sampled every rising edge
//   mode       : 0 = unsigned decimal, 1 = signed decimal
//   ip         : instruction pointer, shown as two hex digits
//   hex0..hex3 : decimal digits (hex0 = units, hex3 = sign)
//   hex4/hex5  : ip low / high nibble
//   busy       : high while a conversion is in progress
// Build option: define SEG_DISPLAY_SIGNED_EN to enable signed mode. Without it
// mode is ignored, every value is unsigned and hex3 stays blank.
// A conversion is IDLE -> LOAD -> 8 x SHIFT -> UPDATE; the display registers
// change only in UPDATE, so a half-converted value is never visible.
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int CONV_BITS      = 8
) (
  input  logic                 clk,
  input  logic                 resetn_deb,
  input  logic [CONV_BITS-1:0] dout,
  input  logic                 dval,
  input  logic                 mode,
  input  logic [7:0]           ip,
  output logic [6:0]           hex0,
  output logic [6:0]           hex1,
  output logic [6:0]           hex2,
  output logic [6:0]           hex3,
  output logic [6:0]           hex4,
  output logic [6:0]           hex5,
  output logic                 busy
);

  logic [1:0]           state;
  logic [CONV_BITS-1:0] val_q;
  logic                 mode_q;
  logic                 pending;
  logic                 neg_q;
  dd_t                  dd_q;
  logic [2:0]           cnt;
  logic [11:0]          disp_bcd;
  logic                 disp_neg;
  logic                 disp_on;
  logic [7:0]           ip_q;
  logic                 ip_on;

  logic                 mode_chg;
  logic                 neg_c;
  logic [7:0]           mag_c;

`ifdef SEG_DISPLAY_SIGNED_EN
  assign mode_chg = (mode != mode_q);
  assign neg_c    = mode_q & val_q[7];
`else
  logic unused_mode;
  assign unused_mode = mode ^ mode_q;
  assign mode_chg    = 1'b0;
  assign neg_c       = 1'b0;
`endif

  // Two's-complement negation keeps 8 bits, so 0x80 yields a magnitude of 128.
  assign mag_c = neg_c ? (~val_q + 8'd1) : val_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge resetn_deb) begin
    if (!resetn_deb) begin
      state    <= ST_IDLE;
      val_q    <= '0;
      mode_q   <= 1'b0;
      pending  <= 1'b1;  // forces a conversion of 0 straight after release
      neg_q    <= 1'b0;
      dd_q     <= '0;
      cnt      <= '0;
      disp_bcd <= '0;
      disp_neg <= 1'b0;
      disp_on  <= 1'b0;
    end else begin
      if (dval) val_q <= dout;
      mode_q <= mode;

      // A new request on the same edge as LOAD wins: LOAD has already taken
      // the old snapshot, so the new value must trigger another conversion.
      if (dval || mode_chg)     pending <= 1'b1;
      else if (state == ST_LOAD) pending <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (pending) state <= ST_LOAD;
        end
        ST_LOAD: begin
          dd_q  <= '{hun: 4'd0, ten: 4'd0, one: 4'd0, bin: mag_c};
          neg_q <= neg_c;
          cnt   <= '0;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          dd_q <= dd_step(dd_q);
          cnt  <= cnt + 3'd1;
          if (cnt == 3'(SHIFT_ITERS - 1)) state <= ST_UPDATE;
        end
        ST_UPDATE: begin
          disp_bcd <= {dd_q.hun, dd_q.ten, dd_q.one};
          disp_neg <= neg_q;
          disp_on  <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn_deb) begin
    if (!resetn_deb) begin
      ip_q  <= '0;
      ip_on <= 1'b0;
    end else begin
      ip_q  <= ip;
      ip_on <= 1'b1;
    end
  end

  assign busy = (state != ST_IDLE);

  // Leading-zero blanking: hundreds blank when 0, tens blank when both upper
  // digits are 0, units always shown once a value has been converted.
  logic blank_hun;
  logic blank_ten;
  assign blank_hun = (disp_bcd[11:8] == 4'd0);
  assign blank_ten = blank_hun && (disp_bcd[7:4] == 4'd0);

  seg7_encoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc0 (
    .nibble(disp_bcd[3:0]), .blank(!disp_on), .seg(hex0)
  );
  seg7_encoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc1 (
    .nibble(disp_bcd[7:4]), .blank(!disp_on || blank_ten), .seg(hex1)
  );
  seg7_encoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc2 (
    .nibble(disp_bcd[11:8]), .blank(!disp_on || blank_hun), .seg(hex2)
  );
  seg7_encoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc4 (
    .nibble(ip_q[3:0]), .blank(!ip_on), .seg(hex4)
  );
  seg7_encoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc5 (
    .nibble(ip_q[7:4]), .blank(!ip_on), .seg(hex5)
  );

  // The sign position shows only minus or nothing, so it bypasses the encoder.
  logic [6:0] sign_low;
  assign sign_low = (disp_on && disp_neg) ? SEG_MINUS : SEG_BLANK;
  assign hex3     = SEG_ACTIVE_LOW ? sign_low : ~sign_low;

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter SEG_ACTIVE_LOW, default 1, meaning segment outputs are driven low to light a segment; 0 inverts all segment outputs.
REQ-002 SHALL have parameter CONV_BITS, default 8, meaning width of the converted data value; only 8 is supported.
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 resetn_deb  input  1  asynchronous, active-low reset (already debounced).
REQ-005 dout  input  8  data value to display.
REQ-006 dval  input  1  high: dout valid, sampled every rising clk edge.
REQ-007 mode  input  1  display mode; 0 = unsigned decimal, 1 = signed decimal.
REQ-008 ip  input  8  instruction pointer, shown in hex.
REQ-009 hex0..hex3  output  7 each  decimal display digits, hex0 = units; bit order {g,f,e,d,c,b,a}.
REQ-010 hex4, hex5  output  7 each  ip low and high nibble in hex.
REQ-011 busy  output  1  high while a conversion is in progress.

Function
REQ-012 SHALL register ip each cycle; hex4/hex5 SHALL reflect ip one cycle after it changes, glyphs 0-9 and A-F.
REQ-013 SHALL hold a value register val_q, loaded from dout on any clk edge where dval=1, regardless of FSM state.
REQ-014 SHALL set a pending flag when val_q is loaded or when mode differs from its value registered on the previous cycle.
REQ-015 FSM states: IDLE, LOAD, SHIFT, UPDATE.
REQ-016 IDLE -> LOAD when pending=1; LOAD clears pending, snapshots val_q and mode, and computes magnitude and sign.
REQ-017 Magnitude: mode=0 -> val_q unsigned; mode=1 with val_q[7]=1 -> 8-bit two's-complement negation, so 0x80 gives 128.
REQ-018 SHIFT SHALL perform exactly 8 double-dabble iterations, one per cycle: add 3 to any BCD nibble of 5 or more, then shift left by one bit.
REQ-019 UPDATE SHALL write hex0..hex3, then return to IDLE.
REQ-020 Latency from dval sample to the display change SHALL be 11 cycles: 1 register cycle plus LOAD, 8 SHIFT cycles and UPDATE.
REQ-021 busy SHALL be 1 in LOAD, SHIFT and UPDATE, and 0 in IDLE.
REQ-022 Leading-zero blanking:
  - hundreds digit blank if 0;
  - tens digit blank if hundreds and tens are both 0;
  - units digit always shown.
REQ-023 hex3 SHALL show minus when negative in signed mode, otherwise blank.
REQ-024 A dval or mode change during busy SHALL NOT disturb the current conversion; the latest val_q and mode are converted next, with back-to-back conversions.
REQ-025 Displayed digits SHALL be stable between UPDATE cycles, so no partial result is ever visible.

Reset
REQ-026 While resetn_deb=0: all hex outputs blank, busy=0, state IDLE, val_q=0, registered mode=0.
REQ-027 While resetn_deb=0, pending SHALL be set to 1, so that "0" appears on hex0 11 cycles after release.
REQ-028 Reset asserted mid-conversion SHALL abort the conversion immediately and discard the partial result.

Configuration
REQ-029 Macro SEG_DISPLAY_SIGNED_EN defined: signed mode as in REQ-017 and REQ-023.
REQ-030 Macro SEG_DISPLAY_SIGNED_EN undefined: mode is ignored, mode changes do not set pending, all values are unsigned, and hex3 is always blank.

Structure
REQ-031 Package seg_display_pkg SHALL hold:
  - FSM state encodings;
  - glyph constants SEG_BLANK, SEG_MINUS (active-low form);
  - SHIFT iteration count 8.
REQ-032 A combinational sub-module seg7_encoder SHALL map a 4-bit nibble plus a blank flag to 7 segments, applying SEG_ACTIVE_LOW; one instance per digit.

Verification
REQ-033 Release reset; wait 11 cycles -> hex0=0 glyph (7'b1000000), hex1..hex3 blank, busy pulse seen.
REQ-034 mode=0, dout=0xFF, dval for 1 cycle -> after 11 cycles hex2..hex0 = 2,5,5; hex3 blank.
REQ-035 mode=1, dout=0x80 -> "-128" (hex3 SEG_MINUS); then dout=0xFB -> "-5" with hex1 and hex2 blank.
REQ-036 dout=0x07 then dout=0x2A three cycles later, during busy -> 7 displayed, then 42 exactly 11 cycles after the first UPDATE.
REQ-037 ip=0x3C -> next cycle hex5=3, hex4=C; with the macro undefined, toggling mode with held value 0xFB -> 251 unchanged and no busy pulse.
REQ-038 Assert reset during SHIFT -> outputs blank asynchronously; after release, "0" displayed, not the aborted value.
